// File: rtl/matrix_operand_loader.sv
// Operand feeder for matrix_mult. It collects matrix A and then matrix B one element per beat,
// and holds both until the multiplier accepts them. Optional load_clr: MATRIX_LOADER_CLEAR_EN.
module matrix_operand_loader #(
   parameter int unsigned ROWS   = 2,
   parameter int unsigned COLS   = 2,
   parameter int unsigned ELEM_W = 2,
   localparam int unsigned N     = ROWS * COLS,
   localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ELEM_W-1:0]   in_data,
   output logic [N*ELEM_W-1:0] mat_a,
   output logic [N*ELEM_W-1:0] mat_b,
   output logic                mat_valid,
   input  logic                mat_ready,
`ifdef MATRIX_LOADER_CLEAR_EN
   input  logic                load_clr,
`endif
   output logic [1:0]          load_phase,
   output logic [IW-1:0]       elem_idx
);

   typedef enum logic [1:0] {
      StLoadA = 2'd0,
      StLoadB = 2'd1,
      StHold  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [N*ELEM_W-1:0] mat_a_q, mat_b_q;
   logic                clr;
   logic                accept;
   logic                last;
   logic                wr_a, wr_b;

`ifdef MATRIX_LOADER_CLEAR_EN
   assign clr = load_clr;
`else
   assign clr = 1'b0;
`endif

   // Ready and valid come from registered state only, so valid never feeds back into ready.
   assign in_ready   = (state_q != StHold);
   assign mat_valid  = (state_q == StHold);
   assign load_phase = state_q;
   assign elem_idx   = idx_q;
   assign mat_a      = mat_a_q;
   assign mat_b      = mat_b_q;

   assign accept = in_valid & in_ready;
   assign last   = (idx_q == IW'(N - 1));
   assign wr_a   = accept & ~clr & (state_q == StLoadA);
   assign wr_b   = accept & ~clr & (state_q == StLoadB);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (clr) begin
         state_d = StLoadA;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            StLoadA: begin
               if (accept) begin
                  if (last) begin
                     idx_d   = '0;
                     state_d = StLoadB;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            StLoadB: begin
               if (accept) begin
                  if (last) begin
                     idx_d   = '0;
                     state_d = StHold;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            StHold: begin
               if (mat_ready) begin
                  state_d = StLoadA;
               end
            end
            default: begin
               state_d = StLoadA;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StLoadA;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Operand storage is not cleared after transfer; each element is overwritten on reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mat_a_q <= '0;
         mat_b_q <= '0;
      end else begin
         if (wr_a) begin
            mat_a_q[idx_q*ELEM_W +: ELEM_W] <= in_data;
         end
         if (wr_b) begin
            mat_b_q[idx_q*ELEM_W +: ELEM_W] <= in_data;
         end
      end
   end

endmodule
